pcie_tx_block_gearbox: RTL and testbench
========================================

// Module: pcie_tx_block_gearbox
// PURPOSE
//  128b/130b block encoder + 130->128 gearbox for the PCIe Gen3 PHY TX path; sits directly downstream of the scrambler.
//  Accepts one scrambled 128-bit payload per handshake, prepends its 2-bit sync header and packs the 130-bit blocks into a 128-bit lane stream.
//  Every 64 input blocks the accumulated 128 header bits are flushed as one extra output word, with input stalled for that cycle.
// PARAMETERS
//  DATA_WIDTH  128  payload/output width; only 128 is supported (elaboration error otherwise)
//  FLUSH_BLKS  64   derived = DATA_WIDTH/2; blocks per gearbox cycle, not user-overridable
// PORTS
//  clk        in   1    clock; all logic on rising edge
//  reset_n    in   1    asynchronous, active-low reset
//  data_in    in   128  scrambled block payload, bit 0 transmitted first
//  sync_hdr   in   2    sync header; 2'b10 = data block, 2'b01 = ordered-set block; bit 0 transmitted first
//  in_valid   in   1    data_in/sync_hdr valid
//  in_ready   out  1    block accepted when in_valid && in_ready
//  data_out   out  128  packed lane word, bit 0 transmitted first
//  out_valid  out  1    data_out valid
//  out_ready  in   1    downstream accepts data_out when out_valid && out_ready
//  hdr_err    out  1    sticky illegal-header flag (PCIE_GBX_HDR_CHECK_EN only; tied 0 otherwise)
// BEHAVIOUR
//  - State: phase[6:0] 0..64, residue[127:0] holding 2*phase valid LSBs, registered output word.
//  - Reset (reset_n=0, async): phase=0, residue=0, data_out=0, out_valid=0, hdr_err=0; in_ready=0 while reset_n=0.
//  - advance = !out_valid || out_ready (output register free this cycle).
//  - in_ready = advance && (phase != 64); combinational from registered state and out_ready.
//  - Pack phase k<64, on accept: blk = {data_in, sync_hdr} (130b, hdr in LSBs);
//    data_out <= lower 128b of {blk, residue[2k-1:0]}; residue <= upper 2(k+1) bits; phase <= k+1; out_valid <= 1.
//  - Flush phase 64, when advance: data_out <= residue[127:0]; phase <= 0; residue <= 0; out_valid <= 1; no input consumed.
//  - advance && phase<64 && !in_valid: out_valid <= 0; phase/residue hold (idle gap, no bubble data emitted).
//  - !advance: all state holds; data_out/out_valid stable until taken (AXI-style; no drop, no duplicate).
//  - Latency: one cycle from accept to out_valid. Throughput: 64 words in / 65 words out per gearbox cycle.
//  - Flush is never skipped or delayed by in_valid; it occurs on the first advance cycle with phase==64.
//  - Reset mid-operation discards residue and partial gearbox cycle; next accepted block starts at phase 0.
//  - Header value is not interpreted by the packer; any 2-bit value is packed as given.
// CONFIGURATION
//  PCIE_GBX_HDR_CHECK_EN defined: on accept with sync_hdr ∈ {2'b00, 2'b11}, hdr_err <= 1 (sticky until reset);
//    block still packed unchanged.
//  Not defined: no check logic; hdr_err driven constant 0.
// TESTING
//  1 Reset, out_ready=1, block data_in=all-ones, hdr=2'b10
//    -> next cycle out_valid=1, data_out=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, phase=1, residue[1:0]=2'b11.
//  2 64 back-to-back blocks data_in=0, hdr=2'b01, out_ready=1
//    -> in_ready low exactly on the 65th cycle; flush word = {64{2'b01}} = 128'h5555_..._5555; phase returns to 0.
//  3 out_ready=0 for 5 cycles mid-stream -> in_ready=0, data_out/out_valid frozen; release -> no lost/duplicated words;
//    concatenated output matches the reference 130b bitstream.
//  4 Random in_valid (50%) and out_ready (70%) over 1000 blocks -> output bitstream equals serial concatenation of {data,hdr} blocks.
//  5 Assert reset_n=0 at phase 30 -> outputs 0 immediately (async); after release, first block packs as in scenario 1.
//  6 With PCIE_GBX_HDR_CHECK_EN: hdr=2'b11 at block 3 -> hdr_err=1 next cycle and stays 1; packed data unchanged.
//    Without: hdr_err stays 0.

Source files
------------

// File: rtl/pcie_tx_block_gearbox.sv
// pcie_tx_block_gearbox
//   128b/130b block encoder and 130->128 gearbox for the PCIe Gen3 PHY TX lane.
//   Each accepted 128-bit scrambled payload gets its 2-bit sync header prepended
//   in the LSBs, and the 130-bit block is packed into the 128-bit lane stream.
//   After 64 blocks the residue holds exactly 128 bits. It is emitted as one extra
//   word, and input is stalled for that cycle.
//   Optional build macro: PCIE_GBX_HDR_CHECK_EN enables the sticky hdr_err flag.
//   This flag is set when an accepted block carries a header of 2'b00 or 2'b11.

module pcie_tx_block_gearbox #(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            sync_hdr,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  hdr_err
);

    localparam int         FLUSH_BLKS  = DATA_WIDTH / 2;
    localparam logic [6:0] FLUSH_PHASE = 7'(FLUSH_BLKS);

    if (DATA_WIDTH != 128) begin : g_width_check
        $error("pcie_tx_block_gearbox: only DATA_WIDTH=128 is supported");
    end

    logic [6:0]   phase_q, phase_d;
    logic [127:0] residue_q, residue_d;
    logic [127:0] data_q, data_d;
    logic         valid_q, valid_d;

    logic         advance;
    logic         at_flush;
    logic         accept;
    logic [129:0] blk;
    logic [6:0]   shift_amt;
    logic [255:0] packed_w;

    // Handshake: the output register is free when empty or being taken this cycle.
    always_comb begin
        advance  = !valid_q || out_ready;
        at_flush = (phase_q == FLUSH_PHASE);
        in_ready = reset_n && advance && !at_flush;
        accept   = in_valid && in_ready;
    end

    // The residue occupies bits [2k-1:0] and everything above it is zero.
    // The new block is shifted in above the residue.
    always_comb begin
        blk       = {data_in, sync_hdr};
        shift_amt = {phase_q[5:0], 1'b0};
        packed_w  = {128'b0, residue_q} | (256'(blk) << shift_amt);
    end

    // Next state: flush has priority at phase 64.
    // An idle cycle with a free output drops out_valid.
    always_comb begin
        phase_d   = phase_q;
        residue_d = residue_q;
        data_d    = data_q;
        valid_d   = valid_q;
        if (advance) begin
            if (at_flush) begin
                data_d    = residue_q;
                residue_d = '0;
                phase_d   = '0;
                valid_d   = 1'b1;
            end else if (in_valid) begin
                data_d    = packed_w[127:0];
                residue_d = packed_w[255:128];
                phase_d   = phase_q + 7'd1;
                valid_d   = 1'b1;
            end else begin
                valid_d   = 1'b0;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= '0;
            residue_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            residue_q <= residue_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;

`ifdef PCIE_GBX_HDR_CHECK_EN
    logic hdr_err_q, hdr_err_d;

    // Sticky flag for headers that are neither data (2'b10) nor ordered set (2'b01).
    always_comb begin
        hdr_err_d = hdr_err_q | (accept && (sync_hdr[0] == sync_hdr[1]));
    end

    // Sticky error register; only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hdr_err_q <= 1'b0;
        else          hdr_err_q <= hdr_err_d;
    end

    assign hdr_err = hdr_err_q;
`else
    assign hdr_err = 1'b0;
`endif

endmodule

// File: tb/tb_pcie_tx_block_gearbox.sv
// Testbench for pcie_tx_block_gearbox.
// Directed vector table for the first blocks after reset, hand sequences for
// flush, backpressure and async reset, and a serial-bitstream scoreboard.

module tb_pcie_tx_block_gearbox;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [127:0] data_in;
    logic [1:0]   sync_hdr;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_out;
    logic         out_valid;
    logic         out_ready;
    logic         hdr_err;

    pcie_tx_block_gearbox dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .sync_hdr  (sync_hdr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hdr_err   (hdr_err)
    );

    always #5 clk = ~clk;

`ifdef PCIE_GBX_HDR_CHECK_EN
    localparam logic EXP_HDR_ERR = 1'b1;
`else
    localparam logic EXP_HDR_ERR = 1'b0;
`endif

    typedef struct {
        logic [127:0] d;
        logic [1:0]   h;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [5];

    int   n_total = 0;
    int   n_pass  = 0;
    bit   exp_q [$];
    logic last_acc;
    logic last_in_ready;
    int   words_out;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Called at 1 time unit after a rising edge.
    // Drives inputs, records the handshakes, then advances one cycle.
    task automatic step(input logic [127:0] d, input logic [1:0] h, input logic v, input logic ordy);
        logic [127:0] w;
        data_in   = d;
        sync_hdr  = h;
        in_valid  = v;
        out_ready = ordy;
        #1;
        last_in_ready = in_ready;
        last_acc      = in_valid && in_ready;
        if (out_valid && out_ready) begin
            words_out++;
            if (exp_q.size() < 128) begin
                chk("stream_underflow", 128'(exp_q.size()), 128'd128);
            end else begin
                for (int i = 0; i < 128; i++) w[i] = exp_q.pop_front();
                chk("stream_word", data_out, w);
            end
        end
        if (last_acc) begin
            exp_q.push_back(h[0]);
            exp_q.push_back(h[1]);
            for (int i = 0; i < 128; i++) exp_q.push_back(d[i]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = '0;
        sync_hdr  = 2'b00;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        reset_n = 1'b1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [127:0] held;
        int           acc_cnt;
        int           cyc;
        int           low_cnt;
        int           low_at;

        tbl[0] = '{d: {128{1'b1}}, h: 2'b10, exp: 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE};
        tbl[1] = '{d: 128'h0,      h: 2'b01, exp: 128'h7};
        tbl[2] = '{d: 128'h1,      h: 2'b10, exp: 128'h60};
        tbl[3] = '{d: {1'b1, 127'h0}, h: 2'b11, exp: 128'hC0};
        tbl[4] = '{d: 128'h0,      h: 2'b00, exp: 128'h80};

        // Reset state and first blocks, including the illegal header at block 3.
        do_reset();
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_data_out", data_out, 128'h0);
        chk("rst_hdr_err", 128'(hdr_err), 128'd0);
        for (int i = 0; i < 5; i++) begin
            step(tbl[i].d, tbl[i].h, 1'b1, 1'b1);
            chk("tbl_accept", 128'(last_acc), 128'd1);
            chk("tbl_out_valid", 128'(out_valid), 128'd1);
            chk($sformatf("tbl_data_%0d", i), data_out, tbl[i].exp);
            if (i == 2) chk("hdr_err_before", 128'(hdr_err), 128'd0);
            if (i == 3) chk("hdr_err_set", 128'(hdr_err), 128'(EXP_HDR_ERR));
        end
        step('0, 2'b10, 1'b0, 1'b1);
        chk("idle_out_valid", 128'(out_valid), 128'd0);
        step('0, 2'b10, 1'b0, 1'b1);
        chk("hdr_err_sticky", 128'(hdr_err), 128'(EXP_HDR_ERR));

        // 64 back-to-back blocks, then the flush cycle with in_ready low.
        do_reset();
        low_cnt = 0;
        low_at  = -1;
        for (int i = 0; i < 65; i++) begin
            step({64{2'b01}}, 2'b01, 1'b1, 1'b1);
            if (!last_in_ready) begin
                low_cnt++;
                low_at = i;
            end
        end
        chk("flush_low_count", 128'(low_cnt), 128'd1);
        chk("flush_low_cycle", 128'(low_at), 128'd64);
        chk("flush_word", data_out, {64{2'b01}});
        step({128{1'b1}}, 2'b10, 1'b1, 1'b1);
        chk("post_flush_phase0", data_out, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
        chk("hdr_err_clean", 128'(hdr_err), 128'd0);

        // Five cycles of downstream backpressure in the middle of the stream.
        do_reset();
        for (int i = 0; i < 10; i++) step(rnd128(), 2'b10, 1'b1, 1'b1);
        held = data_out;
        for (int i = 0; i < 5; i++) begin
            step(rnd128(), 2'b01, 1'b1, 1'b0);
            chk("stall_in_ready", 128'(last_in_ready), 128'd0);
            chk("stall_out_valid", 128'(out_valid), 128'd1);
            chk("stall_data_hold", data_out, held);
        end
        for (int i = 0; i < 10; i++) step(rnd128(), 2'b10, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step('0, 2'b10, 1'b0, 1'b1);

        // Random valid/ready over 1024 blocks; the stream must drain completely.
        do_reset();
        acc_cnt   = 0;
        cyc       = 0;
        words_out = 0;
        while (acc_cnt < 1024 && cyc < 20000) begin
            step(rnd128(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) < 7));
            if (last_acc) acc_cnt++;
            cyc++;
        end
        chk("rand_blocks_done", 128'(acc_cnt), 128'd1024);
        cyc = 0;
        while ((out_valid || exp_q.size() != 0) && cyc < 200) begin
            step('0, 2'b10, 1'b0, 1'b1);
            cyc++;
        end
        chk("rand_drain_empty", 128'(exp_q.size()), 128'd0);
        chk("rand_word_count", 128'(words_out), 128'd1040);

        // Asynchronous reset at phase 30, then a restart from phase 0.
        do_reset();
        for (int i = 0; i < 30; i++) step(rnd128(), 2'b11, 1'b1, 1'b1);
        in_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_data_out", data_out, 128'h0);
        chk("async_out_valid", 128'(out_valid), 128'd0);
        chk("async_in_ready", 128'(in_ready), 128'd0);
        chk("async_hdr_err", 128'(hdr_err), 128'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step({128{1'b1}}, 2'b10, 1'b1, 1'b1);
        chk("after_reset_pack", data_out, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
